// File: rtl/mips_pkg.sv
// Shared widths and types for the MIPS pipeline stages.
// The M/WB register contents are grouped in one struct so they reset and stall together.
package mips_pkg;

    localparam int WORD_W         = 32;
    localparam int REG_AW         = 5;
    localparam int DMEM_DEPTH_DEF = 256;

    typedef struct packed {
        logic [WORD_W-1:0] alu_result;
        logic [WORD_W-1:0] read_data;
        logic [REG_AW-1:0] writereg;
        logic              reg_write;
        logic              mem_to_reg;
        logic              misalign;
    } mwb_t;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data memory: combinational read, write on the rising clock edge.
// Contents are not reset.
module dmem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus M/WB pipeline register with writeback result mux.
// Optional alignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int DMEM_AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_M,
    input  logic [WORD_W-1:0] ALUResult_M,
    input  logic [WORD_W-1:0] WriteData_M,
    input  logic [REG_AW-1:0] writereg_M,
    input  logic              RegWrite_M,
    input  logic              MemtoReg_M,
    input  logic              MemWrite_M,
    output logic [WORD_W-1:0] ALUResult_W,
    output logic [WORD_W-1:0] ReadData_W,
    output logic [REG_AW-1:0] writereg_W,
    output logic              RegWrite_W,
    output logic              MemtoReg_W,
    output logic [WORD_W-1:0] Result_W,
    output logic              misalign_W
);

    // Stall contract: stall_M=1 freezes every *_W output and blocks the store;
    // there is no valid/ready pairing, the upstream stage holds its own inputs.
    logic               in_range;
    logic [DMEM_AW-1:0] word_idx;
    logic               misaligned;
    logic               mem_we;
    logic [WORD_W-1:0]  ram_rdata;
    logic [WORD_W-1:0]  read_data;
    mwb_t               mwb_q;

    assign in_range = (ALUResult_M[WORD_W-1:DMEM_AW+2] == '0);
    assign word_idx = ALUResult_M[DMEM_AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = (MemWrite_M | MemtoReg_M) & (|ALUResult_M[1:0]);
`else
    logic unused_byte_offset;
    assign unused_byte_offset = ^ALUResult_M[1:0];
    assign misaligned         = 1'b0;
`endif

    assign mem_we    = MemWrite_M & ~stall_M & ~rst & in_range & ~misaligned;
    assign read_data = in_range ? ram_rdata : '0;

    dmem_ram #(
        .DEPTH (DMEM_DEPTH),
        .AW    (DMEM_AW)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (WriteData_M),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mwb_q <= '0;
        end else if (!stall_M) begin
            mwb_q.alu_result <= ALUResult_M;
            mwb_q.read_data  <= read_data;
            mwb_q.writereg   <= writereg_M;
            // A misaligned load must not commit its (wrong) word to the register file.
            mwb_q.reg_write  <= RegWrite_M & ~(misaligned & MemtoReg_M);
            mwb_q.mem_to_reg <= MemtoReg_M;
            mwb_q.misalign   <= misaligned;
        end
    end

    assign ALUResult_W = mwb_q.alu_result;
    assign ReadData_W  = mwb_q.read_data;
    assign writereg_W  = mwb_q.writereg;
    assign RegWrite_W  = mwb_q.reg_write;
    assign MemtoReg_W  = mwb_q.mem_to_reg;
    assign misalign_W  = mwb_q.misalign;
    assign Result_W    = mwb_q.mem_to_reg ? mwb_q.read_data : mwb_q.alu_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases then randomized traffic
// against a word-array reference model of the data memory and M/WB register.
module tb_mem_wb_stage;

    localparam int DEPTH = 256;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall_M, RegWrite_M, MemtoReg_M, MemWrite_M;
    logic [31:0] ALUResult_M, WriteData_M;
    logic [4:0]  writereg_M;
    logic [31:0] ALUResult_W, ReadData_W, Result_W;
    logic [4:0]  writereg_W;
    logic        RegWrite_W, MemtoReg_W, misalign_W;

    mem_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_M     (stall_M),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .writereg_M  (writereg_M),
        .RegWrite_M  (RegWrite_M),
        .MemtoReg_M  (MemtoReg_M),
        .MemWrite_M  (MemWrite_M),
        .ALUResult_W (ALUResult_W),
        .ReadData_W  (ReadData_W),
        .writereg_W  (writereg_W),
        .RegWrite_W  (RegWrite_W),
        .MemtoReg_W  (MemtoReg_W),
        .Result_W    (Result_W),
        .misalign_W  (misalign_W)
    );

    // reference model state
    logic [31:0] mem_m [DEPTH];
    logic [31:0] e_alu, e_rd;
    logic [4:0]  e_wreg;
    logic        e_rw, e_m2r, e_mis;
    logic [31:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("alu_w",      ALUResult_W, e_alu);
        check("rdata_w",    ReadData_W,  e_rd);
        check("wreg_w",     {27'd0, writereg_W}, {27'd0, e_wreg});
        check("regwrite_w", {31'd0, RegWrite_W}, {31'd0, e_rw});
        check("memtoreg_w", {31'd0, MemtoReg_W}, {31'd0, e_m2r});
        check("misalign_w", {31'd0, misalign_W}, {31'd0, e_mis});
        if (exp_q.size() == 0) check("result_q_empty", 32'd1, 32'd0);
        else                   check("result_w", Result_W, exp_q.pop_front());
    endtask

    // driver: apply one cycle of inputs, advance the model, compare after the edge
    task automatic apply(input logic r, input logic s, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] wr,
                         input logic rw, input logic m2r, input logic mw);
        logic        inr, mis;
        logic [31:0] idx, rd;
        rst = r; stall_M = s; ALUResult_M = a; WriteData_M = wd;
        writereg_M = wr; RegWrite_M = rw; MemtoReg_M = m2r; MemWrite_M = mw;
        @(posedge clk);
        #1;
        if (r) begin
            e_alu = 0; e_rd = 0; e_wreg = 0; e_rw = 0; e_m2r = 0; e_mis = 0;
        end else if (!s) begin
            inr = (a < DEPTH * 4);
            idx = a / 4;
            rd  = inr ? mem_m[idx % DEPTH] : 32'd0;
            mis = MIS_EN && (mw || m2r) && (a % 4 != 0);
            e_alu = a; e_rd = rd; e_wreg = wr; e_m2r = m2r; e_mis = mis;
            e_rw  = rw && !(mis && m2r);
            if (mw && inr && !mis) mem_m[idx % DEPTH] = wd;
        end
        exp_q.push_back(e_m2r ? e_rd : e_alu);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; stall_M = 0; ALUResult_M = 0; WriteData_M = 0;
        writereg_M = 0; RegWrite_M = 0; MemtoReg_M = 0; MemWrite_M = 0;

        apply(1, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);

        // fill memory so every later load has a known expected value
        for (int i = 0; i < DEPTH; i++)
            apply(0, 0, i * 4, $urandom, 5'($urandom), 0, 0, 1);

        // reset with busy inputs: outputs clear and the store is suppressed
        apply(1, 0, 32'h10, 32'h1111_1111, 5'd7, 1, 1, 1);
        apply(1, 1, 32'h10, 32'h2222_2222, 5'd9, 1, 0, 1);
        check("rst_result", Result_W, 32'd0);
        apply(0, 0, 32'h10, 32'h0, 5'd1, 1, 1, 0);

        // store then back-to-back load of the same word
        apply(0, 0, 32'h10, 32'hDEAD_BEEF, 5'd0, 0, 0, 1);
        apply(0, 0, 32'h10, 32'h0, 5'd5, 1, 1, 0);
        check("ld_rdata", ReadData_W, 32'hDEAD_BEEF);
        check("ld_result", Result_W, 32'hDEAD_BEEF);
        check("ld_wreg", {27'd0, writereg_W}, 32'd5);

        // ALU pass-through
        apply(0, 0, 32'h1234, 32'h0, 5'd3, 1, 0, 0);
        check("alu_result", Result_W, 32'h1234);

        // stalled store holds W and does not write
        apply(0, 1, 32'h20, 32'h55, 5'd4, 1, 0, 1);
        check("stall_hold", Result_W, 32'h1234);
        apply(0, 0, 32'h20, 32'h0, 5'd2, 1, 1, 0);
        apply(0, 0, 32'h20, 32'h55, 5'd0, 0, 0, 1);
        apply(0, 0, 32'h20, 32'h0, 5'd2, 1, 1, 0);
        check("unstall_store", ReadData_W, 32'h55);

        // out-of-range store ignored, load returns 0
        apply(0, 0, 32'h400, 32'hCAFE_F00D, 5'd0, 0, 0, 1);
        apply(0, 0, 32'h400, 32'h0, 5'd6, 1, 1, 0);
        check("oor_load", ReadData_W, 32'd0);
        apply(0, 0, 32'h0, 32'h0, 5'd6, 1, 1, 0);

        // byte offsets: checked under the macro, ignored otherwise
        apply(0, 0, 32'h13, 32'h0, 5'd8, 1, 1, 0);
        check("mis_load_data", ReadData_W, 32'hDEAD_BEEF);
        check("mis_load_flag", {31'd0, misalign_W}, {31'd0, MIS_EN});
        check("mis_load_rw", {31'd0, RegWrite_W}, {31'd0, !MIS_EN});
        apply(0, 0, 32'h12, 32'hA5A5_A5A5, 5'd0, 0, 0, 1);
        apply(0, 0, 32'h10, 32'h0, 5'd8, 1, 1, 0);
        check("mis_store", ReadData_W, MIS_EN ? 32'hDEAD_BEEF : 32'hA5A5_A5A5);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            logic [1:0]  kind;
            a = ($urandom_range(0, 9) == 0) ? (32'h400 + $urandom_range(0, 4095))
                                            : 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            kind = 2'($urandom_range(0, 3));
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, a, $urandom,
                  5'($urandom), $urandom_range(0, 1) == 1, kind == 2'd1, kind == 2'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
